// File: rtl/tt_project_pkg.sv
// Shared constants for the 8-bit ripple-carry adder project.
// Imported by the adder top level.
package tt_project_pkg;

    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] ZERO_W = '0;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
// Chained by the top level to form the ripple-carry adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // sum and carry of one bit position
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end

endmodule

// File: rtl/tt_um_project.sv
// 8-bit combinational adder with carry-out status flops.
// The status flops are internal only and have no effect on the outputs.
module tt_um_project
    import tt_project_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [DATA_W:0]   carry;
    logic [DATA_W-1:0] sum;
    logic              c8;

    logic carry_sticky_d;
    logic carry_sticky_q;
    logic carry_last_d;
    logic carry_last_q;

    logic unused_ok;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < DATA_W; i++) begin : g_fa
        full_adder u_fa (
            .a    (ui_in[i]),
            .b    (uio_in[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign c8      = carry[DATA_W];
    assign uo_out  = sum;
    assign uio_out = ZERO_W;
    assign uio_oe  = ZERO_W;

    // status flops drive no port; fold them with ena into a lint sink
    assign unused_ok = &{ena, carry_sticky_q, carry_last_q, 1'b0};

    // next state: sticky accumulates carry-out, last tracks it
    always_comb begin
        carry_sticky_d = carry_sticky_q | c8;
        carry_last_d   = c8;
    end

    // status registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_sticky_q <= 1'b0;
            carry_last_q   <= 1'b0;
        end else begin
            carry_sticky_q <= carry_sticky_d;
            carry_last_q   <= carry_last_d;
        end
    end

endmodule

// File: tb/tb_tt_um_project.sv
// Directed bench for the 8-bit adder and its carry status flops.
// Expected values are hand-computed constants.
module tb_tt_um_project;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int vectors = 0;
    int errs    = 0;

    tt_um_project dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse();
        #1 clk = 1'b1;
        #5 clk = 1'b0;
        #4;
    endtask

    task automatic apply(input string tag, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] s,
                         input logic c);
        ui_in  = a;
        uio_in = b;
        #10;
        check({tag, "_sum"}, uo_out, s);
        check({tag, "_c8"}, {7'd0, dut.c8}, {7'd0, c});
        check({tag, "_uio_out"}, uio_out, 8'h00);
        check({tag, "_uio_oe"}, uio_oe, 8'h00);
    endtask

    initial begin
        clk    = 1'b0;
        ena    = 1'bx;
        rst_n  = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #5;
        check("rst_sticky", {7'd0, dut.carry_sticky_q}, 8'h00);
        check("rst_last", {7'd0, dut.carry_last_q}, 8'h00);
        apply("rst_0p0", 8'h00, 8'h00, 8'h00, 1'b0);
        apply("rst_3p4", 8'h03, 8'h04, 8'h07, 1'b0);
        rst_n = 1'b1;

        apply("v01p01", 8'h01, 8'h01, 8'h02, 1'b0);
        pulse();
        check("v01_sticky", {7'd0, dut.carry_sticky_q}, 8'h00);
        check("v01_last", {7'd0, dut.carry_last_q}, 8'h00);

        apply("v0Fp01", 8'h0F, 8'h01, 8'h10, 1'b0);

        apply("vFFp01", 8'hFF, 8'h01, 8'h00, 1'b1);
        pulse();
        check("vFF_sticky", {7'd0, dut.carry_sticky_q}, 8'h01);
        check("vFF_last", {7'd0, dut.carry_last_q}, 8'h01);

        apply("vAAp55", 8'hAA, 8'h55, 8'hFF, 1'b0);
        pulse();
        check("vAA_last", {7'd0, dut.carry_last_q}, 8'h00);
        check("vAA_sticky", {7'd0, dut.carry_sticky_q}, 8'h01);

        rst_n = 1'b0;
        #2;
        check("arst_sticky", {7'd0, dut.carry_sticky_q}, 8'h00);
        check("arst_last", {7'd0, dut.carry_last_q}, 8'h00);
        check("arst_sum", uo_out, 8'hFF);
        check("arst_uio_oe", uio_oe, 8'h00);

        ui_in  = 8'hFF;
        uio_in = 8'h02;
        rst_n  = 1'b1;
        #4;
        check("rel_sum", uo_out, 8'h01);
        pulse();
        check("rel_sticky", {7'd0, dut.carry_sticky_q}, 8'h01);
        check("rel_last", {7'd0, dut.carry_last_q}, 8'h01);

        apply("v80p80", 8'h80, 8'h80, 8'h00, 1'b1);
        apply("v7Fp80", 8'h7F, 8'h80, 8'hFF, 1'b0);
        pulse();
        check("v7F_last", {7'd0, dut.carry_last_q}, 8'h00);
        check("v7F_sticky", {7'd0, dut.carry_sticky_q}, 8'h01);

        apply("vFFpFF", 8'hFF, 8'hFF, 8'hFE, 1'b1);
        apply("v5Ap3C", 8'h5A, 8'h3C, 8'h96, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
